// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU data-bus responder: ControlBus bits,
// MMIO register offsets, STATUS layout and a status packing helper.
package mem_bus_pkg;

    // ControlBus bit indices
    localparam int CB_READ  = 1;
    localparam int CB_WRITE = 2;

    // MMIO word offsets from MMIO_BASE
    localparam int OFF_TX_DATA = 0;
    localparam int OFF_STATUS  = 1;
    localparam int OFF_CYCLE   = 2;

    // STATUS register bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        SEL_TX_DATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_NONE
    } mmio_sel_e;

    function automatic logic [7:0] pack_status(
        input logic                  empty,
        input logic                  full,
        input logic                  ovf,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [7:0] s;
        s                                  = '0;
        s[ST_EMPTY]                        = empty;
        s[ST_FULL]                         = full;
        s[ST_OVF]                          = ovf;
        s[ST_COUNT_LSB +: ST_COUNT_W]      = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: i_push/i_data write side, i_pop/o_data read side,
// o_full/o_empty/o_count status; synchronous active-low reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A full FIFO still takes a push when the head leaves this cycle.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= w_wr_nxt;
            if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Storage is not reset, so mask the head while empty.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/mem_bus_responder.sv
// CPU data-bus responder: word-addressed data RAM plus an MMIO window
// with a TX byte FIFO (drained by tx_valid/tx_ready), STATUS and CYCLE.
// Ports: clock, rst (sync, active-low), AddressBus, DataBusOut,
// ControlBus in; DataBusIn, tx_valid, tx_data out; tx_ready in.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  RAM_DEPTH  = 1024,
    parameter int                  FIFO_DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] AddressBus,
    input  logic [DATA_WIDTH-1:0] DataBusOut,
    input  logic [2:0]            ControlBus,
    output logic [DATA_WIDTH-1:0] DataBusIn,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);

    localparam int RA = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [31:0]           r_cycle;
    logic                  r_ovf;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_is_mmio;
    logic [DATA_WIDTH-1:0] w_off;
    logic [RA-1:0]         w_ram_idx;
    mmio_sel_e             w_sel;
    logic                  w_ram_wr;
    logic                  w_push;
    logic                  w_pop_ok;
    logic                  w_drop;
    logic                  w_ovf_clr;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [7:0]            w_status;
    logic [DATA_WIDTH-1:0] w_mmio_rdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_unused  = ControlBus[0];

    assign w_rd      = ControlBus[CB_READ];
    assign w_wr      = ControlBus[CB_WRITE];
    assign w_is_mmio = (AddressBus >= MMIO_BASE);
    assign w_off     = AddressBus - MMIO_BASE;
    assign w_ram_idx = AddressBus[RA-1:0];

    always_comb begin
        w_sel = SEL_NONE;
        if (w_is_mmio) begin
            if (w_off == DATA_WIDTH'(OFF_TX_DATA)) begin
                w_sel = SEL_TX_DATA;
            end else if (w_off == DATA_WIDTH'(OFF_STATUS)) begin
                w_sel = SEL_STATUS;
            end else if (w_off == DATA_WIDTH'(OFF_CYCLE)) begin
                w_sel = SEL_CYCLE;
            end
        end
    end

    assign w_ram_wr  = w_wr && !w_is_mmio;
    assign w_push    = w_wr && (w_sel == SEL_TX_DATA);
    assign w_pop_ok  = tx_valid && tx_ready;
    // Overflow only when no slot frees up this cycle.
    assign w_drop    = w_push && w_full && !w_pop_ok;
    assign w_ovf_clr = w_wr && (w_sel == SEL_STATUS)
                       && DataBusOut[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clock),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (DataBusOut[7:0]),
        .i_pop   (tx_ready),
        .o_data  (tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign tx_valid = !w_empty;

    always_ff @(posedge clock) begin
        if (w_ram_wr) begin
            r_mem[w_ram_idx] <= DataBusOut;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_status = pack_status(w_empty, w_full, r_ovf,
                                  ST_COUNT_W'(w_count));

    always_comb begin
        w_mmio_rdata = '0;
        unique case (w_sel)
            SEL_STATUS: w_mmio_rdata = DATA_WIDTH'(w_status);
            SEL_CYCLE:  w_mmio_rdata = DATA_WIDTH'(r_cycle);
            default:    w_mmio_rdata = '0;
        endcase
    end

    // Read sees the RAM before this edge's write: old-value semantics.
    assign w_rdata   = w_is_mmio ? w_mmio_rdata : r_mem[w_ram_idx];
    assign DataBusIn = w_rd ? w_rdata : '0;

endmodule
